// File: rtl/gfx_rom_pkg.sv
// Shared types and widths for the GFX ROM fetch controller and its cycle timer.
`timescale 1ns/1ps
package gfx_rom_pkg;

  localparam int K_AW       = 18;
  localparam int J_AW       = 17;
  localparam int DW         = 16;
  localparam int REQ_AW     = 19;
  localparam int REGION_BIT = 18;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    CAPTURE,
    RECOVER
  } fetch_state_e;

  // The timer counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/gfx_rom_cycle_timer.sv
// Loadable 4-bit down-counter; done is high while the count sits at zero.
`timescale 1ns/1ps
module gfx_rom_cycle_timer
  import gfx_rom_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/gfx_rom_fetch.sv
// Fetch controller for the K13/K19 (lower) and J13/J19 (upper) asynchronous GFX ROMs:
// one request at a time, programmable setup/access/recovery, 32-bit word out.
`timescale 1ns/1ps
module gfx_rom_fetch
  import gfx_rom_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned WAIT_CYCLES    = 2,
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESn,
  input  logic              REQ,
  input  logic [REQ_AW-1:0] REQ_ADDR,
  output logic              READY,
  output logic [K_AW-1:0]   K_ADDR,
  output logic              K_CEn,
  output logic [J_AW-1:0]   J_ADDR,
  output logic              J_CEn,
  output logic              OEn,
  input  logic [DW-1:0]     K13_DATA,
  input  logic [DW-1:0]     K19_DATA,
  input  logic [DW-1:0]     J13_DATA,
  input  logic [DW-1:0]     J19_DATA,
  output logic [2*DW-1:0]   DOUT,
  output logic              DVALID,
  output logic              DERR
);

  fetch_state_e      state_q, state_d;
  logic              ready_q, ready_d;
  logic [K_AW-1:0]   k_addr_q, k_addr_d;
  logic [J_AW-1:0]   j_addr_q, j_addr_d;
  logic              k_cen_q, k_cen_d;
  logic              j_cen_q, j_cen_d;
  logic              oen_q, oen_d;
  logic [2*DW-1:0]   dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              derr_q, derr_d;
  logic              sel_k_q, sel_k_d;
  logic              sel_j_q, sel_j_d;
  logic [2*DW-1:0]   rom_word;
  logic              bus_active;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic              timer_done;

  gfx_rom_cycle_timer u_timer (
    .clk      (CLK),
    .rst_n    (RESn),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Neither pair selected means the upper-region address is past the 128K J ROMs.
  always_comb begin
    rom_word = '0;
    if (sel_k_q) begin
      rom_word = {K19_DATA, K13_DATA};
    end else if (sel_j_q) begin
      rom_word = {J19_DATA, J13_DATA};
    end
  end

  always_comb begin
    state_d    = state_q;
    k_addr_d   = k_addr_q;
    j_addr_d   = j_addr_q;
    sel_k_d    = sel_k_q;
    sel_j_d    = sel_j_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    derr_d     = 1'b0;
    timer_val  = '0;

    case (state_q)
      IDLE: begin
        if (REQ) begin
          state_d = SETUP;
          sel_k_d = !REQ_ADDR[REGION_BIT];
          sel_j_d = REQ_ADDR[REGION_BIT] && !REQ_ADDR[REGION_BIT-1];
          if (sel_k_d) k_addr_d = REQ_ADDR[K_AW-1:0];
          if (sel_j_d) j_addr_d = REQ_ADDR[J_AW-1:0];
        end
      end
      SETUP: begin
        if (timer_done) state_d = ACCESS;
      end
      ACCESS: begin
        if (timer_done) begin
          state_d  = CAPTURE;
          dout_d   = rom_word;
          dvalid_d = 1'b1;
          derr_d   = !(sel_k_q || sel_j_q);
        end
      end
      CAPTURE: begin
        state_d = (RECOVER_CYCLES == 0) ? IDLE : RECOVER;
      end
      RECOVER: begin
        if (timer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    timer_load = (state_d != state_q);
    case (state_d)
      SETUP:   timer_val = cnt_load(SETUP_CYCLES);
      ACCESS:  timer_val = cnt_load(WAIT_CYCLES);
      RECOVER: timer_val = cnt_load(RECOVER_CYCLES);
      default: timer_val = '0;
    endcase

    // Strobes follow the state being entered so they are registered alongside it.
    bus_active = (state_d == SETUP) || (state_d == ACCESS);
    k_cen_d    = !(bus_active && sel_k_d);
    j_cen_d    = !(bus_active && sel_j_d);
    oen_d      = (state_d != ACCESS);
    ready_d    = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      k_addr_q <= '0;
      j_addr_q <= '0;
      k_cen_q  <= 1'b1;
      j_cen_q  <= 1'b1;
      oen_q    <= 1'b1;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      derr_q   <= 1'b0;
      sel_k_q  <= 1'b0;
      sel_j_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      k_addr_q <= k_addr_d;
      j_addr_q <= j_addr_d;
      k_cen_q  <= k_cen_d;
      j_cen_q  <= j_cen_d;
      oen_q    <= oen_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      derr_q   <= derr_d;
      sel_k_q  <= sel_k_d;
      sel_j_q  <= sel_j_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RESn && state_q == ACCESS && timer_done && (sel_k_q || sel_j_q)) begin
      assert (!$isunknown(rom_word))
        else $error("gfx_rom_fetch: ROM data unknown at capture (%h)", rom_word);
    end
  end
`endif

  assign READY  = ready_q;
  assign K_ADDR = k_addr_q;
  assign J_ADDR = j_addr_q;
  assign K_CEn  = k_cen_q;
  assign J_CEn  = j_cen_q;
  assign OEn    = oen_q;
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign DERR   = derr_q;

endmodule

// File: tb/tb_gfx_rom_fetch.sv
// Directed bench for gfx_rom_fetch: default-timing instance plus a SETUP=2/WAIT=4/RECOVER=0 instance.
`timescale 1ns/1ps
module tb_gfx_rom_fetch;

  logic        clk = 1'b0;
  logic        resn = 1'b1;
  logic        req = 1'b0;
  logic [18:0] req_addr = '0;
  logic        ready, k_cen, j_cen, oen, dvalid, derr;
  logic [17:0] k_addr;
  logic [16:0] j_addr;
  logic [31:0] dout;
  logic [15:0] k13, k19, j13, j19;

  logic        s_req = 1'b0;
  logic [18:0] s_addr = '0;
  logic        s_ready, s_kcen, s_jcen, s_oen, s_dvalid, s_derr;
  logic [17:0] s_kaddr;
  logic [16:0] s_jaddr;
  logic [31:0] s_dout;
  logic [15:0] s_k13, s_k19, s_j13, s_j19;

  logic [15:0] k13_v = '0, k19_v = '0, j13_v = '0, j19_v = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  bit rdy_pend = 0;
  int acc_q[$];
  logic [31:0] sb_dout[$];
  logic        sb_derr[$];

  always #21 clk = ~clk;

  gfx_rom_fetch u_dut (
    .CLK(clk), .RESn(resn), .REQ(req), .REQ_ADDR(req_addr), .READY(ready),
    .K_ADDR(k_addr), .K_CEn(k_cen), .J_ADDR(j_addr), .J_CEn(j_cen), .OEn(oen),
    .K13_DATA(k13), .K19_DATA(k19), .J13_DATA(j13), .J19_DATA(j19),
    .DOUT(dout), .DVALID(dvalid), .DERR(derr)
  );

  gfx_rom_fetch #(.SETUP_CYCLES(2), .WAIT_CYCLES(4), .RECOVER_CYCLES(0)) u_sw (
    .CLK(clk), .RESn(resn), .REQ(s_req), .REQ_ADDR(s_addr), .READY(s_ready),
    .K_ADDR(s_kaddr), .K_CEn(s_kcen), .J_ADDR(s_jaddr), .J_CEn(s_jcen), .OEn(s_oen),
    .K13_DATA(s_k13), .K19_DATA(s_k19), .J13_DATA(s_j13), .J19_DATA(s_j19),
    .DOUT(s_dout), .DVALID(s_dvalid), .DERR(s_derr)
  );

  // 70 ns ROMs: outputs undefined until access time has elapsed after OEn falls.
  always @(oen) begin
    if (oen) begin
      k13 = 'x; k19 = 'x; j13 = 'x; j19 = 'x;
    end else begin
      #70;
      if (!oen) begin
        k13 = k_cen ? 'x : k13_v; k19 = k_cen ? 'x : k19_v;
        j13 = j_cen ? 'x : j13_v; j19 = j_cen ? 'x : j19_v;
      end
    end
  end

  always @(s_oen) begin
    if (s_oen) begin
      s_k13 = 'x; s_k19 = 'x; s_j13 = 'x; s_j19 = 'x;
    end else begin
      #70;
      if (!s_oen) begin
        s_k13 = s_kcen ? 'x : k13_v; s_k19 = s_kcen ? 'x : k19_v;
        s_j13 = s_jcen ? 'x : j13_v; s_j19 = s_jcen ? 'x : j19_v;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Scoreboard and latency monitor for the default instance.
  always @(negedge clk) begin
    cyc++;
    if (!resn) begin
      acc_q.delete();
      rdy_pend = 0;
    end else begin
      if (rdy_pend && ready) begin
        chk("ready_latency", cyc - last_acc, 6);
        rdy_pend = 0;
      end
      if (req && ready) begin
        acc_q.push_back(cyc);
        last_acc = cyc;
        rdy_pend = 1;
      end
      if (dvalid) begin
        if (sb_dout.size() == 0 || acc_q.size() == 0) begin
          chk("dvalid_unexpected", 1, 0);
        end else begin
          chk("dout", dout, sb_dout.pop_front());
          chk("derr", derr, sb_derr.pop_front());
          chk("dvalid_latency", cyc - acc_q.pop_front(), 4);
        end
      end else if (derr !== 1'b0) begin
        chk("derr_without_dvalid", derr, 0);
      end
    end
  end

  task automatic drive_req(input logic [18:0] a, input logic [31:0] exp_d,
                           input logic exp_e, input bit hold);
    bit got = 0;
    @(posedge clk); #1;
    req = 1'b1;
    req_addr = a;
    sb_dout.push_back(exp_d);
    sb_derr.push_back(exp_e);
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (ready) got = 1;
    end
    if (!got) chk("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
  endtask

  task automatic watch(input int n, input logic [17:0] k_exp, input logic [16:0] j_exp,
                       output int k_low, output int j_low, output int oen_low,
                       output int k_bad, output int j_bad);
    k_low = 0; j_low = 0; oen_low = 0; k_bad = 0; j_bad = 0;
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      if (!k_cen) k_low++;
      if (!j_cen) j_low++;
      if (!oen) oen_low++;
      if (k_addr !== k_exp) k_bad++;
      if (j_addr !== j_exp) j_bad++;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int kl, jl, ol, kb, jb;
    logic kcen_hist[1:12];
    int first_low2, gap_high, addr_bad, oen_cnt, dv_r, rdy_r;
    logic [31:0] dv_dout;
    logic dv_derr;
    bit got;

    #2 resn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_k_cen", k_cen, 1);
    chk("rst_j_cen", j_cen, 1);
    chk("rst_oen", oen, 1);
    chk("rst_k_addr", k_addr, 0);
    chk("rst_j_addr", j_addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_derr", derr, 0);
    resn = 1'b1;
    repeat (2) @(negedge clk);

    // Lower region
    k13_v = 16'hBEEF; k19_v = 16'hCAFE;
    drive_req(19'h0_1234, 32'hCAFEBEEF, 1'b0, 0);
    watch(6, 18'h01234, 17'h0, kl, jl, ol, kb, jb);
    chk("lo_k_cen_low_cycles", kl, 3);
    chk("lo_j_cen_low_cycles", jl, 0);
    chk("lo_oen_low_cycles", ol, 2);
    chk("lo_k_addr_stable", kb, 0);

    // Upper region
    j13_v = 16'h1111; j19_v = 16'h2222;
    drive_req(19'h4_0ABC, 32'h22221111, 1'b0, 0);
    watch(6, 18'h01234, 17'h00ABC, kl, jl, ol, kb, jb);
    chk("up_j_cen_low_cycles", jl, 3);
    chk("up_k_cen_low_cycles", kl, 0);
    chk("up_oen_low_cycles", ol, 2);
    chk("up_j_addr_stable", jb, 0);

    // Out of range
    drive_req(19'h6_0000, 32'h0, 1'b1, 0);
    watch(6, 18'h01234, 17'h00ABC, kl, jl, ol, kb, jb);
    chk("oor_k_cen_low_cycles", kl, 0);
    chk("oor_j_cen_low_cycles", jl, 0);
    chk("oor_oen_low_cycles", ol, 2);

    // Back-to-back with REQ held
    k13_v = 16'h5A5A; k19_v = 16'hA5A5;
    drive_req(19'h0_0010, 32'hA5A55A5A, 1'b0, 1);
    req_addr = 19'h0_0020;
    sb_dout.push_back(32'hA5A55A5A);
    sb_derr.push_back(1'b0);
    addr_bad = 0;
    for (int r = 1; r <= 12; r++) begin
      @(negedge clk);
      kcen_hist[r] = k_cen;
      if (k_addr !== ((r <= 6) ? 18'h00010 : 18'h00020)) addr_bad++;
      if (r == 6) begin
        chk("b2b_ready_at_n6", ready, 1);
        @(posedge clk); #1;
        req = 1'b0;
      end
    end
    gap_high = 0;
    for (int r = 4; r <= 5; r++) if (kcen_hist[r] === 1'b1) gap_high++;
    first_low2 = 0;
    for (int r = 12; r >= 7; r--) if (kcen_hist[r] === 1'b0) first_low2 = r;
    chk("b2b_cen_high_capture_recover", gap_high, 2);
    chk("b2b_second_cen_start", first_low2, 7);
    chk("b2b_k_addr_stable", addr_bad, 0);

    // Reset during the second OEn-low cycle
    drive_req(19'h0_0100, 32'hA5A55A5A, 1'b0, 0);
    @(posedge clk);
    @(posedge clk); #5;
    chk("mid_rst_pre_oen", oen, 0);
    resn = 1'b0;
    #1;
    chk("mid_rst_k_cen", k_cen, 1);
    chk("mid_rst_oen", oen, 1);
    chk("mid_rst_ready", ready, 1);
    got = 0;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      if (dvalid) got = 1;
      if (r == 1) resn = 1'b1;
    end
    chk("mid_rst_no_dvalid", got, 0);
    sb_dout.delete();
    sb_derr.delete();

    // Timing sweep instance
    got = 0;
    @(posedge clk); #1;
    s_req = 1'b1;
    s_addr = 19'h0_0100;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (s_ready) got = 1;
    end
    if (!got) chk("sw_accept_timeout", 0, 1);
    @(posedge clk); #1;
    s_req = 1'b0;
    oen_cnt = 0; dv_r = 0; rdy_r = 0; dv_dout = '0; dv_derr = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      if (!s_oen) oen_cnt++;
      if (s_dvalid && dv_r == 0) begin
        dv_r = r; dv_dout = s_dout; dv_derr = s_derr;
      end
      if (s_ready && rdy_r == 0) rdy_r = r;
    end
    chk("sw_oen_low_cycles", oen_cnt, 4);
    chk("sw_dvalid_cycle", dv_r, 7);
    chk("sw_ready_cycle", rdy_r, 8);
    chk("sw_dout", dv_dout, 32'hA5A55A5A);
    chk("sw_derr", dv_derr, 0);
    chk("sw_k_addr", s_kaddr, 18'h00100);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb_dout.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gfx_rom_fetch.md
Name: gfx_rom_fetch

Overview:
- Synchronous fetch controller that sits directly upstream of the four asynchronous GFX ROMs.
  - K13/K19: lower region, 256Kx16 each.
  - J13/J19: upper region, 128Kx16 each.
- Accepts one 19-bit word-address request at a time from the tile/sprite pixel pipeline.
- Decodes region bit H18, drives the addressed ROM pair's address and CEn/OEn with programmable setup/access/recovery timing, and returns one 32-bit word (x13 = low half, x19 = high half) with a valid pulse.

Parameters:
- SETUP_CYCLES, 1, cycles with address and CEn valid and OEn high before output enable; range 1..7.
- WAIT_CYCLES, 2, cycles with OEn low before data is sampled; covers the 70 ns access time at 24 MHz; range 1..15.
- RECOVER_CYCLES, 1, cycles with all CEn/OEn high after capture (bus turnaround); range 0..7.

Ports:
- CLK  in  1  system clock.
- RESn  in  1  asynchronous active-low reset.
- REQ  in  1  fetch request; held with REQ_ADDR until accepted.
- REQ_ADDR  in  19  bit 18 = H18 region select; bits 17:0 = word address.
- READY  out  1  block can accept a request this cycle.
- K_ADDR  out  18  address to K13/K19.
- K_CEn  out  1  chip enable, K13/K19 (active low).
- J_ADDR  out  17  address to J13/J19.
- J_CEn  out  1  chip enable, J13/J19 (active low).
- OEn  out  1  shared output enable (active low).
- K13_DATA  in  16  K13 data; low half in lower region.
- K19_DATA  in  16  K19 data; high half in lower region.
- J13_DATA  in  16  J13 data; low half in upper region.
- J19_DATA  in  16  J19 data; high half in upper region.
- DOUT  out  32  fetched word, valid while DVALID is high.
- DVALID  out  1  one-cycle pulse marking DOUT valid.
- DERR  out  1  qualifies DVALID: address out of range.

Behaviour:
- Reset (async, RESn low): state IDLE, READY=1, K_CEn=J_CEn=OEn=1, K_ADDR=0, J_ADDR=0, DOUT=0, DVALID=0, DERR=0. Mid-access reset releases the ROM bus in the same instant; the pending request is lost.
- Acceptance happens on a rising edge where REQ=1 and READY=1.
  - REQ_ADDR is latched, and K_ADDR/J_ADDR stay stable until the last RECOVER cycle.
  - Requests while READY=0 are ignored; the requester must hold them.
- FSM states:
  - IDLE: READY=1; on accept, go to SETUP.
  - SETUP: selected CEn=0, OEn=1; stays SETUP_CYCLES cycles, then ACCESS.
  - ACCESS: selected CEn=0, OEn=0; stays WAIT_CYCLES cycles. DOUT is registered on the edge ending the last ACCESS cycle; then CAPTURE.
  - CAPTURE: one cycle, DVALID=1, CEn/OEn=1; then RECOVER, or IDLE if RECOVER_CYCLES=0.
  - RECOVER: CEn/OEn=1; stays RECOVER_CYCLES cycles, then IDLE.
- READY=1 only in IDLE.
- Latency with defaults: accept edge at cycle N; DVALID high in cycle N+4; READY high again in cycle N+6. One fetch per 6 cycles.
- Region decode:
  - H18=0: K_CEn asserted, K_ADDR=REQ_ADDR[17:0], J_CEn held 1; DOUT={K19_DATA,K13_DATA}.
  - H18=1 and REQ_ADDR[17]=0: J_CEn asserted, J_ADDR=REQ_ADDR[16:0], K_CEn held 1; DOUT={J19_DATA,J13_DATA}.
- Out of range (H18=1, REQ_ADDR[17]=1):
  - Full FSM timing still runs, but no CEn is ever asserted and OEn still toggles.
  - DOUT=0 and DERR=1 for the CAPTURE cycle.
- DERR=0 whenever DVALID=0.
- DOUT holds its value after CAPTURE until the next capture.
- Counter: a single down-counter (4 bits) reloaded on every state entry with count-1. The state advances when it reaches 0. No wrap.
- Sim-only check: assert that sampled data contains no X/Z bits when a CEn is active.

Decomposition:
- gfx_rom_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS, CAPTURE, RECOVER);
  - widths K_AW=18, J_AW=17, DW=16, REQ_AW=19;
  - the region-bit index (18).
- One sub-module: gfx_rom_cycle_timer, a loadable 4-bit down-counter with a done flag, used by SETUP, ACCESS and RECOVER.

Test Plan:
- Reset mid-ACCESS (RESn low in the 2nd OEn-low cycle) -> K_CEn/OEn go to 1 without a clock edge; READY=1; DVALID never pulses.
- Lower-region fetch: REQ_ADDR=19'h0_1234, K13=16'hBEEF, K19=16'hCAFE (70 ns model) -> K_ADDR=18'h01234, J_CEn=1 throughout; DVALID at N+4 with DOUT=32'hCAFEBEEF, DERR=0.
- Upper-region fetch: REQ_ADDR=19'h4_0ABC, J13=16'h1111, J19=16'h2222 -> J_ADDR=17'h00ABC, K_CEn=1 throughout; DOUT=32'h22221111.
- Out of range: REQ_ADDR=19'h6_0000 -> K_CEn=J_CEn=1 for the whole transaction; DVALID at N+4 with DOUT=0, DERR=1.
- Back-to-back: REQ held high with two addresses -> second accepted at N+6; CEn high for exactly 2 cycles (CAPTURE+RECOVER) between accesses; K_ADDR stable throughout each access.
- Parameter sweep: SETUP_CYCLES=2, WAIT_CYCLES=4, RECOVER_CYCLES=0 -> OEn low for exactly 4 cycles; DVALID at N+7; READY at N+8.
